// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared AXI field-width defines and small helpers for the easyaxi read arbiter.
// The defines are guarded so that any other file of the codebase that also
// provides them does not clash.
`ifndef EASYAXI_AXI_DEFINES
`define EASYAXI_AXI_DEFINES
`define AXI_ID_W      4
`define AXI_ADDR_W    32
`define AXI_DATA_W    32
`define AXI_LEN_W     8
`define AXI_SIZE_W    3
`define AXI_BURST_W   2
`define AXI_RESP_W    2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package easyaxi_rd_arb_pkg;

    // Width of an index over n masters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..lim inclusive.
    function automatic int cnt_width(input int lim);
        return $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/easyaxi_rr_arb.sv
// Combinational round-robin arbiter: searches req starting at ptr and returns
// a one-hot grant plus the encoded winner. Nothing is granted while en is low.
module easyaxi_rr_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   cand;

    // Walk the requesters in rotated order and keep the first one found.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// Round-robin AXI read-channel arbiter: NUM_MST masters share one read slave.
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; valid never waits for ready, and a raised valid holds its payload
// stable until that transfer.
// Accepted ARs carry the master index in the upper ARID bits; R beats are
// routed back by those bits. Per-master outstanding counters throttle masters.
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter  int NUM_MST   = 2,
    parameter  int OST_LIMIT = 4,
    localparam int MST_IDX_W = idx_width(NUM_MST),
    localparam int CNT_W     = cnt_width(OST_LIMIT)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // master AR
    input  logic [NUM_MST-1:0]                mst_arvalid,
    output logic [NUM_MST-1:0]                mst_arready,
    input  logic [NUM_MST*`AXI_ID_W-1:0]      mst_arid,
    input  logic [NUM_MST*`AXI_ADDR_W-1:0]    mst_araddr,
    input  logic [NUM_MST*`AXI_LEN_W-1:0]     mst_arlen,
    input  logic [NUM_MST*`AXI_SIZE_W-1:0]    mst_arsize,
    input  logic [NUM_MST*`AXI_BURST_W-1:0]   mst_arburst,
    // master R
    output logic [NUM_MST-1:0]                mst_rvalid,
    input  logic [NUM_MST-1:0]                mst_rready,
    output logic [`AXI_ID_W-1:0]              mst_rid,
    output logic [`AXI_DATA_W-1:0]            mst_rdata,
    output logic [`AXI_RESP_W-1:0]            mst_rresp,
    output logic                              mst_rlast,
    // slave AR
    output logic                              slv_arvalid,
    input  logic                              slv_arready,
    output logic [`AXI_ID_W-1:0]              slv_arid,
    output logic [`AXI_ADDR_W-1:0]            slv_araddr,
    output logic [`AXI_LEN_W-1:0]             slv_arlen,
    output logic [`AXI_SIZE_W-1:0]            slv_arsize,
    output logic [`AXI_BURST_W-1:0]           slv_arburst,
    // slave R
    input  logic                              slv_rvalid,
    output logic                              slv_rready,
    input  logic [`AXI_ID_W-1:0]              slv_rid,
    input  logic [`AXI_DATA_W-1:0]            slv_rdata,
    input  logic [`AXI_RESP_W-1:0]            slv_rresp,
    input  logic                              slv_rlast,
    // debug view of internal state
    output logic [NUM_MST*CNT_W-1:0]          dbg_ost_cnt,
    output logic [MST_IDX_W-1:0]              dbg_prio_ptr
);

    localparam int LOW_W = `AXI_ID_W - MST_IDX_W;

    logic [CNT_W-1:0]         ost_cnt [NUM_MST];
    logic [MST_IDX_W-1:0]     prio_ptr;
    logic [NUM_MST-1:0]       req;
    logic [NUM_MST-1:0]       grant;
    logic [MST_IDX_W-1:0]     win_idx;
    logic                     out_free;
    logic                     arb_en;
    logic                     ar_accept;
    logic [NUM_MST-1:0]       r_dec;
    logic [MST_IDX_W-1:0]     r_idx;
    logic                     r_ready_sel;
    logic                     r_last_hs;

    logic [LOW_W-1:0]         sel_id;
    logic [`AXI_ADDR_W-1:0]   sel_addr;
    logic [`AXI_LEN_W-1:0]    sel_len;
    logic [`AXI_SIZE_W-1:0]   sel_size;
    logic [`AXI_BURST_W-1:0]  sel_burst;

    // The output register can take a new request when empty or draining now.
    // Reset also blocks granting so no master sees arready while in reset.
    assign out_free  = ~slv_arvalid | slv_arready;
    assign arb_en    = out_free & rst_n;
    assign ar_accept = |grant;
    assign mst_arready = grant;

    // A master is eligible while it is below its outstanding limit.
    always_comb begin
        req = '0;
        for (int g = 0; g < NUM_MST; g++) begin
            req[g] = mst_arvalid[g] & (ost_cnt[g] < CNT_W'(OST_LIMIT));
        end
    end

    easyaxi_rr_arb #(
        .N (NUM_MST)
    ) u_rr_arb (
        .req   (req),
        .ptr   (prio_ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (win_idx)
    );

    // Select the winning master's AR payload; only the low ARID bits survive.
    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int g = 0; g < NUM_MST; g++) begin
            if (grant[g]) begin
                sel_id    = mst_arid[g*`AXI_ID_W +: LOW_W];
                sel_addr  = mst_araddr[g*`AXI_ADDR_W +: `AXI_ADDR_W];
                sel_len   = mst_arlen[g*`AXI_LEN_W +: `AXI_LEN_W];
                sel_size  = mst_arsize[g*`AXI_SIZE_W +: `AXI_SIZE_W];
                sel_burst = mst_arburst[g*`AXI_BURST_W +: `AXI_BURST_W];
            end
        end
    end

    // AR output register: load on accept, clear valid once the slave takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_arvalid <= 1'b0;
            slv_arid    <= '0;
            slv_araddr  <= '0;
            slv_arlen   <= '0;
            slv_arsize  <= '0;
            slv_arburst <= '0;
        end else if (ar_accept) begin
            slv_arvalid <= 1'b1;
            slv_arid    <= {win_idx, sel_id};
            slv_araddr  <= sel_addr;
            slv_arlen   <= sel_len;
            slv_arsize  <= sel_size;
            slv_arburst <= sel_burst;
        end else if (slv_arready) begin
            slv_arvalid <= 1'b0;
        end
    end

    // Priority moves to the master after the winner on every accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= '0;
        end else if (ar_accept) begin
            if (win_idx == MST_IDX_W'(NUM_MST - 1)) begin
                prio_ptr <= '0;
            end else begin
                prio_ptr <= win_idx + MST_IDX_W'(1);
            end
        end
    end

    // R demux: route by the tag bits; unknown tags are sunk and dropped.
    assign r_idx = slv_rid[`AXI_ID_W-1 -: MST_IDX_W];

    always_comb begin
        mst_rvalid  = '0;
        r_ready_sel = 1'b1;
        for (int g = 0; g < NUM_MST; g++) begin
            if (r_idx == MST_IDX_W'(g)) begin
                mst_rvalid[g] = slv_rvalid;
                r_ready_sel   = mst_rready[g];
            end
        end
    end

    assign slv_rready = r_ready_sel;
    assign mst_rid    = {{MST_IDX_W{1'b0}}, slv_rid[LOW_W-1:0]};
    assign mst_rdata  = slv_rdata;
    assign mst_rresp  = slv_rresp;
    assign mst_rlast  = slv_rlast;
    assign r_last_hs  = slv_rvalid & slv_rready & slv_rlast;

    // Per-master burst completions seen on the R channel.
    always_comb begin
        r_dec = '0;
        for (int g = 0; g < NUM_MST; g++) begin
            r_dec[g] = r_last_hs & (r_idx == MST_IDX_W'(g));
        end
    end

    // Outstanding counters: +1 on accept, -1 on RLAST, saturating at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_MST; g++) begin
                ost_cnt[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_MST; g++) begin
                if (grant[g] && !r_dec[g]) begin
                    ost_cnt[g] <= ost_cnt[g] + CNT_W'(1);
                end else if (r_dec[g] && !grant[g] && (ost_cnt[g] != '0)) begin
                    ost_cnt[g] <= ost_cnt[g] - CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counters for observation.
    always_comb begin
        dbg_ost_cnt = '0;
        for (int g = 0; g < NUM_MST; g++) begin
            dbg_ost_cnt[g*CNT_W +: CNT_W] = ost_cnt[g];
        end
    end

    assign dbg_prio_ptr = prio_ptr;

`ifndef SYNTHESIS
    // An RLAST for a master with nothing outstanding is a slave protocol error.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < NUM_MST; g++) begin
                assert (!(r_dec[g] && !grant[g] && (ost_cnt[g] == '0)))
                else $error("easyaxi_rd_arb: RLAST underflow on master %0d", g);
            end
        end
    end
`endif

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Directed bench for easyaxi_rd_arb with two masters and an outstanding limit
// of two. Forwarded AR payloads are checked against an expected queue.
module tb_easyaxi_rd_arb;

    localparam int NM = 2;
    localparam int OL = 2;
    localparam int AW = `AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W + `AXI_SIZE_W + `AXI_BURST_W;

    logic                           clk;
    logic                           rst_n;
    logic [NM-1:0]                  mst_arvalid;
    logic [NM-1:0]                  mst_arready;
    logic [NM*`AXI_ID_W-1:0]        mst_arid;
    logic [NM*`AXI_ADDR_W-1:0]      mst_araddr;
    logic [NM*`AXI_LEN_W-1:0]       mst_arlen;
    logic [NM*`AXI_SIZE_W-1:0]      mst_arsize;
    logic [NM*`AXI_BURST_W-1:0]     mst_arburst;
    logic [NM-1:0]                  mst_rvalid;
    logic [NM-1:0]                  mst_rready;
    logic [`AXI_ID_W-1:0]           mst_rid;
    logic [`AXI_DATA_W-1:0]         mst_rdata;
    logic [`AXI_RESP_W-1:0]         mst_rresp;
    logic                           mst_rlast;
    logic                           slv_arvalid;
    logic                           slv_arready;
    logic [`AXI_ID_W-1:0]           slv_arid;
    logic [`AXI_ADDR_W-1:0]         slv_araddr;
    logic [`AXI_LEN_W-1:0]          slv_arlen;
    logic [`AXI_SIZE_W-1:0]         slv_arsize;
    logic [`AXI_BURST_W-1:0]        slv_arburst;
    logic                           slv_rvalid;
    logic                           slv_rready;
    logic [`AXI_ID_W-1:0]           slv_rid;
    logic [`AXI_DATA_W-1:0]         slv_rdata;
    logic [`AXI_RESP_W-1:0]         slv_rresp;
    logic                           slv_rlast;
    logic [NM*2-1:0]                dbg_ost_cnt;
    logic [0:0]                     dbg_prio_ptr;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_word;
    int checks;
    int errors;

    easyaxi_rd_arb #(
        .NUM_MST   (NM),
        .OST_LIMIT (OL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mst_arvalid  (mst_arvalid),
        .mst_arready  (mst_arready),
        .mst_arid     (mst_arid),
        .mst_araddr   (mst_araddr),
        .mst_arlen    (mst_arlen),
        .mst_arsize   (mst_arsize),
        .mst_arburst  (mst_arburst),
        .mst_rvalid   (mst_rvalid),
        .mst_rready   (mst_rready),
        .mst_rid      (mst_rid),
        .mst_rdata    (mst_rdata),
        .mst_rresp    (mst_rresp),
        .mst_rlast    (mst_rlast),
        .slv_arvalid  (slv_arvalid),
        .slv_arready  (slv_arready),
        .slv_arid     (slv_arid),
        .slv_araddr   (slv_araddr),
        .slv_arlen    (slv_arlen),
        .slv_arsize   (slv_arsize),
        .slv_arburst  (slv_arburst),
        .slv_rvalid   (slv_rvalid),
        .slv_rready   (slv_rready),
        .slv_rid      (slv_rid),
        .slv_rdata    (slv_rdata),
        .slv_rresp    (slv_rresp),
        .slv_rlast    (slv_rlast),
        .dbg_ost_cnt  (dbg_ost_cnt),
        .dbg_prio_ptr (dbg_prio_ptr)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int g, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
        mst_arid[g*`AXI_ID_W +: `AXI_ID_W]       = id;
        mst_araddr[g*`AXI_ADDR_W +: `AXI_ADDR_W] = addr;
        mst_arlen[g*`AXI_LEN_W +: `AXI_LEN_W]    = len;
    endtask

    // Expected slave-side AR: tag in the ID MSB, master ID low bits, fixed size/burst.
    function automatic logic [AW-1:0] ar_word(input logic tag, input logic [3:0] id,
                                              input logic [31:0] addr, input logic [7:0] len);
        return {tag, id[2:0], addr, len, 3'd2, 2'b01};
    endfunction

    // scoreboard: every AR handshake on the slave side pops one expected entry
    always @(negedge clk) begin
        if (rst_n && slv_arvalid && slv_arready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL ar_unexpected observed=0x%0h expected=none",
                       {slv_arid, slv_araddr, slv_arlen, slv_arsize, slv_arburst});
            end else begin
                exp_word = exp_q.pop_front();
                chk("ar_fwd", {slv_arid, slv_araddr, slv_arlen, slv_arsize, slv_arburst}, exp_word);
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        mst_arvalid = '0;
        mst_arid    = '0;
        mst_araddr  = '0;
        mst_arlen   = '0;
        mst_arsize  = {NM{3'd2}};
        mst_arburst = {NM{2'b01}};
        mst_rready  = '0;
        slv_arready = 1'b0;
        slv_rvalid  = 1'b0;
        slv_rid     = '0;
        slv_rdata   = '0;
        slv_rresp   = '0;
        slv_rlast   = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_slv_arvalid", slv_arvalid, 0);
        chk("rst_mst_arready", mst_arready, 0);
        chk("rst_mst_rvalid", mst_rvalid, 0);
        chk("rst_ost_cnt", dbg_ost_cnt, 0);
        chk("rst_prio_ptr", dbg_prio_ptr, 0);
        chk("rst_slv_araddr", slv_araddr, 0);
        chk("rst_slv_arid", slv_arid, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single master: ARID 3, addr 0x10, len 3
        set_ar(0, 4'h3, 32'h10, 8'd3);
        mst_arvalid = 2'b01;
        slv_arready = 1'b1;
        mst_rready  = 2'b11;
        @(negedge clk);
        chk("single_arready", mst_arready, 2'b01);
        exp_q.push_back(ar_word(1'b0, 4'h3, 32'h10, 8'd3));
        tick();
        mst_arvalid = 2'b00;
        @(negedge clk);
        chk("single_slv_arvalid", slv_arvalid, 1);
        chk("single_slv_arid", slv_arid, 4'h3);
        chk("single_ost_1", dbg_ost_cnt, 4'b0001);
        chk("single_ptr", dbg_prio_ptr, 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            slv_rvalid = 1'b1;
            slv_rid    = 4'h3;
            slv_rdata  = 32'hA000 + 32'(b);
            slv_rlast  = (b == 3);
            @(negedge clk);
            chk("single_r_valid", mst_rvalid, 2'b01);
            chk("single_r_ready", slv_rready, 1);
            chk("single_r_data", mst_rdata, 32'hA000 + 32'(b));
            chk("single_r_id", mst_rid, 4'h3);
            tick();
        end
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        @(negedge clk);
        chk("single_ost_0", dbg_ost_cnt, 0);
        chk("single_ar_drained", slv_arvalid, 0);
        tick();

        // short reset so fairness starts at priority 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ptr_cleared", dbg_prio_ptr, 0);
        tick();

        // fairness: both masters request; RLASTs retire the previous grant
        set_ar(0, 4'hA, 32'h200, 8'd1);
        set_ar(1, 4'hE, 32'h300, 8'd2);
        mst_arvalid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            slv_rvalid = (k > 0);
            slv_rid    = (k % 2 == 1) ? 4'h0 : 4'h8;
            slv_rlast  = 1'b1;
            @(negedge clk);
            chk("fair_grant", mst_arready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("fair_rvalid", mst_rvalid, (k % 2 == 1) ? 2'b01 : 2'b10);
            if (k % 2 == 0) exp_q.push_back(ar_word(1'b0, 4'hA, 32'h200, 8'd1));
            else            exp_q.push_back(ar_word(1'b1, 4'hE, 32'h300, 8'd2));
            tick();
        end
        mst_arvalid = 2'b00;
        slv_rvalid  = 1'b1;
        slv_rid     = 4'h8;
        slv_rlast   = 1'b1;
        @(negedge clk);
        chk("fair_last_rvalid", mst_rvalid, 2'b10);
        chk("fair_last_arid", slv_arid, 4'hE);
        tick();
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        @(negedge clk);
        chk("fair_ost", dbg_ost_cnt, 0);
        chk("fair_ptr", dbg_prio_ptr, 0);
        tick();

        // throttle: master 1 hits the limit, master 0 still gets through
        set_ar(1, 4'h1, 32'h400, 8'd0);
        mst_arvalid = 2'b10;
        for (int a = 0; a < 2; a++) begin
            @(negedge clk);
            chk("thr_m1_accept", mst_arready, 2'b10);
            exp_q.push_back(ar_word(1'b1, 4'h1, 32'h400, 8'd0));
            tick();
        end
        @(negedge clk);
        chk("thr_m1_blocked", mst_arready, 2'b00);
        chk("thr_ost_full", dbg_ost_cnt, 4'b1000);
        tick();
        set_ar(0, 4'h0, 32'h500, 8'd0);
        mst_arvalid = 2'b11;
        @(negedge clk);
        chk("thr_m0_passes", mst_arready, 2'b01);
        exp_q.push_back(ar_word(1'b0, 4'h0, 32'h500, 8'd0));
        tick();
        mst_arvalid = 2'b10;
        slv_rvalid  = 1'b1;
        slv_rid     = 4'h8;
        slv_rlast   = 1'b1;
        @(negedge clk);
        chk("thr_still_blocked", mst_arready, 2'b00);
        chk("thr_rlast_route", mst_rvalid, 2'b10);
        chk("thr_ost_before", dbg_ost_cnt, 4'b1001);
        tick();
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        @(negedge clk);
        chk("thr_m1_reaccept", mst_arready, 2'b10);
        exp_q.push_back(ar_word(1'b1, 4'h1, 32'h400, 8'd0));
        tick();
        set_ar(0, 4'h2, 32'h510, 8'd0);
        mst_arvalid = 2'b01;
        @(negedge clk);
        chk("thr_m0_second", mst_arready, 2'b01);
        exp_q.push_back(ar_word(1'b0, 4'h2, 32'h510, 8'd0));
        tick();
        mst_arvalid = 2'b00;
        slv_arready = 1'b0;
        @(negedge clk);
        chk("pre_rst_arvalid", slv_arvalid, 1);
        chk("pre_rst_ost", dbg_ost_cnt, 4'b1010);
        chk("pre_rst_ptr", dbg_prio_ptr, 1);
        chk("pre_rst_araddr", slv_araddr, 32'h510);
        tick();

        // reset mid-operation: everything clears while rst_n is low
        rst_n       = 1'b0;
        mst_arvalid = 2'b11;
        @(negedge clk);
        chk("midrst_arvalid", slv_arvalid, 0);
        chk("midrst_arready", mst_arready, 2'b00);
        chk("midrst_ost", dbg_ost_cnt, 0);
        chk("midrst_araddr", slv_araddr, 0);
        chk("midrst_arid", slv_arid, 0);
        chk("midrst_rvalid", mst_rvalid, 0);
        exp_q.delete();
        tick();
        rst_n       = 1'b1;
        mst_arvalid = 2'b00;
        @(negedge clk);
        chk("postrst_ptr", dbg_prio_ptr, 0);
        tick();

        // backpressure: payload holds while the slave stalls
        slv_arready = 1'b0;
        set_ar(0, 4'h5, 32'h600, 8'd7);
        mst_arvalid = 2'b01;
        @(negedge clk);
        chk("bp_first_accept", mst_arready, 2'b01);
        exp_q.push_back(ar_word(1'b0, 4'h5, 32'h600, 8'd7));
        tick();
        set_ar(0, 4'h4, 32'h700, 8'd0);
        set_ar(1, 4'h3, 32'h800, 8'd0);
        mst_arvalid = 2'b11;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp_no_arready", mst_arready, 2'b00);
            chk("bp_arvalid", slv_arvalid, 1);
            chk("bp_araddr", slv_araddr, 32'h600);
            chk("bp_arid", slv_arid, 4'h5);
            tick();
        end
        slv_arready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", mst_arready, 2'b10);
        exp_q.push_back(ar_word(1'b1, 4'h3, 32'h800, 8'd0));
        tick();
        mst_arvalid = 2'b00;
        @(negedge clk);
        chk("bp_next_araddr", slv_araddr, 32'h800);
        tick();
        @(negedge clk);
        chk("bp_ost", dbg_ost_cnt, 4'b0101);
        tick();

        // R routing with rready held low on the target master
        slv_rvalid = 1'b1;
        slv_rid    = 4'hD;
        slv_rlast  = 1'b1;
        slv_rdata  = 32'hBEEF;
        mst_rready = 2'b01;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("rr_slv_rready_low", slv_rready, 0);
            chk("rr_rvalid", mst_rvalid, 2'b10);
            chk("rr_rid", mst_rid, 4'h5);
            tick();
        end
        mst_rready = 2'b11;
        @(negedge clk);
        chk("rr_slv_rready_high", slv_rready, 1);
        chk("rr_rvalid_hs", mst_rvalid, 2'b10);
        chk("rr_rdata", mst_rdata, 32'hBEEF);
        tick();
        slv_rvalid = 1'b0;
        @(negedge clk);
        chk("rr_ost_after", dbg_ost_cnt, 4'b0001);
        tick();
        slv_rvalid = 1'b1;
        slv_rid    = 4'h0;
        slv_rlast  = 1'b1;
        tick();
        slv_rvalid = 1'b0;
        slv_rlast  = 1'b0;
        @(negedge clk);
        chk("final_ost", dbg_ost_cnt, 0);
        chk("final_queue_empty", exp_q.size(), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/easyaxi_rd_arb.md
# easyaxi_rd_arb

Round-robin read-channel arbiter that shares one AXI read slave port (AR + R) among NUM_MST read masters. It sits between the masters and the outstanding-capable read slave. Each accepted AR is tagged with the master index in the upper ARID bits, and R beats are routed back by RID. Per-master outstanding counters throttle any master that reaches OST_LIMIT.

## Interface
- NUM_MST, 2: number of masters, 2..4; MST_IDX_W = clog2(NUM_MST), minimum 1.
- OST_LIMIT, 4: maximum outstanding bursts per master, 1..15; count width = clog2(OST_LIMIT+1).
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- mst_arvalid / mst_arready  in/out  NUM_MST  per-master AR handshake.
- mst_arid / araddr / arlen / arsize / arburst  in  NUM_MST×field width  flattened AR payloads; master g uses slice g.
- mst_rvalid / mst_rready  out/in  NUM_MST  per-master R handshake.
- mst_rid / rdata / rresp / rlast  out  field width  R payload broadcast to all masters, qualified by mst_rvalid[g].
- slv_arvalid / slv_arready  out/in  1  AR handshake to the slave.
- slv_arid / araddr / arlen / arsize / arburst  out  field widths  registered AR payload.
- slv_rvalid / slv_rready  in/out  1  R handshake from the slave.
- slv_rid / rdata / rresp / rlast  in  field widths  R payload from the slave.
- Field widths come from the shared `AXI_*_W defines.

## Operation
- **AR output register (ar_q):**
  - Holds one request. out_free = ~slv_arvalid | slv_arready.
  - Requests are loaded only when out_free is high.
- **Eligibility:** req[g] = mst_arvalid[g] & (ost_cnt[g] < OST_LIMIT).
- **Arbitration:**
  - Round-robin over req starting at prio_ptr.
  - The winner gets mst_arready[g] = out_free & grant[g], combinationally in the same cycle. All other masters see arready=0.
  - On accept, prio_ptr <= (winner+1) mod NUM_MST. With no accept, prio_ptr holds.
- **Tagging:**
  - slv_arid = {winner index, mst_arid[g][AXI_ID_W-MST_IDX_W-1:0]}.
  - The upper MST_IDX_W bits of master ARID are ignored.
  - Other AR fields are copied unchanged.
- **R routing:**
  - r_idx = slv_rid[AXI_ID_W-1 -: MST_IDX_W].
  - mst_rvalid[g] = slv_rvalid & (r_idx==g).
  - slv_rready = mst_rready[r_idx].
  - mst_rid = {MST_IDX_W'b0, slv_rid low bits}.
  - If r_idx >= NUM_MST: slv_rready=1, the beat is dropped, and no mst_rvalid asserts.
- **Outstanding counters:**
  - ost_cnt[g] increments on mst AR accept (g).
  - It decrements on slv_rvalid & slv_rready & slv_rlast & r_idx==g.
  - Increment and decrement in the same cycle leave it unchanged.
  - A decrement at 0 is a protocol error. The counter saturates at 0, and a simulation-only assertion flags it.
- AR and R paths are independent. An accept and an R-last for the same master may coincide.

## Timing
- Reset values: slv_arvalid=0, ar_q payload=0, mst_arready=0, mst_rvalid=0, all ost_cnt=0, prio_ptr=0.
- slv_rready follows the masters' rready combinationally, so it is not a register output.
- AR latency: master handshake at cycle N, slv_arvalid high at N+1.
- Back-to-back: if slv_arready=1 each cycle, one AR is forwarded per cycle (full throughput).
- Stall: with slv_arvalid=1 and slv_arready=0, ar_q payload stays stable and every mst_arready is 0.
- R path: zero latency, purely combinational. No R buffering.
- Throttle: once ost_cnt[g]==OST_LIMIT, master g is skipped from the next cycle onward.
  - It becomes eligible again in the cycle after its RLAST handshake.
- Reset asserted mid-operation: all state clears immediately. In-flight bursts are forgotten, and the slave must be reset together with the arbiter.

## Structure
- The shared define header (existing `AXI_*_W, `AXI_BURST_*, `AXI_RESP_*) supplies all field widths. No new package is needed.
- MST_IDX_W and the counter width are local params.
- Sub-module easyaxi_rr_arb:
  - Parameter N.
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot grant[N] and encoded winner index.
  - Purely combinational, reused later for the write-channel arbiter.
- Top level holds ar_q, prio_ptr, the counters and R demux: roughly 200 lines.

## Test plan
- **Single master:** master 0 issues ARID=3, addr=0x10, len=3 with slv_arready=1 → slv_arvalid at the next cycle with slv_arid={0,3}. Four R beats return to master 0 only, and ost_cnt[0] goes 1→0 after rlast.
- **Fairness:** both masters hold arvalid for 6 cycles, slv_arready=1 → grant order 0,1,0,1,0,1 and slv_arid upper bit alternates.
- **Throttle:** OST_LIMIT=2, slave never returns R → master 1 gets 2 accepts, then mst_arready[1]=0 while master 0 still gets through. One RLAST for ID tag 1 → master 1 is accepted again the next cycle.
- **Backpressure:** slv_arready=0 for 5 cycles → ar_q payload is constant, no mst_arready pulses, and the request is forwarded on the cycle slv_arready rises.
- **R routing / rready:** slave returns rid={1,5} with mst_rready[1]=0 for 3 cycles → slv_rready=0 and mst_rvalid[0]=0 throughout. The handshake completes when mst_rready[1] rises, and mst_rid=5.
- **Reset mid-burst:** assert rst_n=0 with ost_cnt={2,1} and slv_arvalid=1 → all outputs and counters read 0 in that cycle, and prio_ptr=0 after release.
